// File: rtl/uart_tx_serializer_if.sv
// TX FIFO read-port handshake between the FIFO (master) and the serializer (slave).
// A byte transfers on a clock where tx_valid_i & tx_ready_o are both high.
interface uart_tx_serializer_if;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;

    modport master (output tx_data_i, output tx_valid_i, input tx_ready_o);
    modport slave  (input tx_data_i, input tx_valid_i, output tx_ready_o);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them out as
// start / 5-8 data bits (LSB first) / optional even parity / 1-2 stop bits.
// Frame configuration is snapshotted at the pop, so later cfg changes only
// affect the next frame.
// Optional feature: define UART_TX_BREAK_EN to add break_i, which forces the
// line low and blocks pops while the FSM keeps running underneath.
module uart_tx_serializer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 cfg_en_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic                 cfg_parity_en_i,
    input  logic [1:0]           cfg_bits_i,
    input  logic                 cfg_stop_bits_i,
`ifdef UART_TX_BREAK_EN
    input  logic                 break_i,
`endif
    uart_tx_serializer_if.slave  fifo,
    output logic                 tx_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;

    // per-frame snapshot
    logic [DIV_WIDTH-1:0] div_q;
    logic [2:0]           last_q;
    logic                 par_en_q;
    logic                 stop2_q;
    logic                 par_q;

    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic                 handshake;
    logic                 bit_done;
    logic [7:0]           data_masked;

    // Only idle + enabled can pop; held low in reset so a FIFO can never
    // lose a byte to a flop that is being held.
`ifdef UART_TX_BREAK_EN
    assign fifo.tx_ready_o = (state_q == S_IDLE) & cfg_en_i & rstn_i & ~break_i;
`else
    assign fifo.tx_ready_o = (state_q == S_IDLE) & cfg_en_i & rstn_i;
`endif

    assign handshake   = fifo.tx_valid_i & fifo.tx_ready_o;
    assign bit_done    = (baud_q == div_q);
    // unused upper data bits are cleared so parity only sees transmitted bits
    assign data_masked = fifo.tx_data_i & (8'hFF >> (2'd3 - cfg_bits_i));

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Datapath registers: counters, shifter, frame snapshot, registered outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            div_q    <= '0;
            last_q   <= '0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (handshake) begin
                div_q    <= cfg_div_i;
                last_q   <= 3'd4 + {1'b0, cfg_bits_i};
                par_en_q <= cfg_parity_en_i;
                stop2_q  <= cfg_stop_bits_i;
                par_q    <= ^data_masked;
            end
        end
    end

    // Next-state and counter/shifter update
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        // every non-idle state lasts div+1 clocks; counter wraps at div
        if (state_q != S_IDLE)
            baud_d = bit_done ? '0 : baud_q + DIV_WIDTH'(1);
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (handshake) begin
                    state_d = S_START;
                    shift_d = data_masked;
                end
            end
            S_START: if (bit_done) state_d = S_DATA;
            S_DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == last_q) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: if (bit_done) state_d = S_STOP1;
            S_STOP1:  if (bit_done) state_d = stop2_q ? S_STOP2 : S_IDLE;
            S_STOP2:  if (bit_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from next state so tx_o/busy_o can be registered
    always_comb begin
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
`ifdef UART_TX_BREAK_EN
        if (break_i) tx_d = 1'b0;
`endif
    end

endmodule
